// File: rtl/bus_arbiter_6.sv
// bus_arbiter_6: round-robin arbiter for six req/gnt masters sharing one
// 6:1 bus mux. Drives a registered one-hot grant plus the mux select; when
// the bus is free the select parks on SEL_IDLE so the mux outputs zero.
// Optional feature macro: ARB_TIMEOUT_EN (forced release after MAX_HOLD
// BUSY cycles, flagged by a one-cycle timeout pulse).
module bus_arbiter_6 #(
  parameter logic [2:0]  SEL_IDLE = 3'd7,
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] req,
  output logic [5:0] gnt,
  output logic [2:0] sel,
  output logic       busy,
  output logic       timeout
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    TURN
  } state_t;

  // Reject parameter values that would alias a real mux input or overflow the hold counter.
  if (SEL_IDLE < 3'd6) begin : g_bad_sel_idle
    $error("bus_arbiter_6: SEL_IDLE must be 6 or 7");
  end
  if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("bus_arbiter_6: MAX_HOLD must be in 1..255");
  end

  state_t     state, state_n;
  logic [2:0] ptr, ptr_n;
  logic [5:0] gnt_n;
  logic [2:0] sel_n;
  logic       busy_n;
  logic       win_valid;
  logic [2:0] win_idx;
  logic       owner_req;

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
  logic [7:0] hold, hold_n;
  logic       timeout_n;
`endif

  // Round-robin scan: first pending request starting at ptr, wrapping 5 -> 0.
  always_comb begin
    logic [3:0] cand;
    win_valid = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int unsigned i = 0; i < 6; i++) begin
      cand = {1'b0, ptr} + 4'(i);
      if (cand >= 4'd6) cand = cand - 4'd6;
      if (!win_valid && req[cand[2:0]]) begin
        win_valid = 1'b1;
        win_idx   = cand[2:0];
      end
    end
  end

  // sel holds the owner index whenever the FSM is in BUSY.
  assign owner_req = req[sel];

  // Next-state and next-output decode for the IDLE/BUSY/TURN handshake FSM.
  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    gnt_n   = gnt;
    sel_n   = sel;
    busy_n  = busy;
`ifdef ARB_TIMEOUT_EN
    hold_n    = hold;
    timeout_n = 1'b0;
`endif
    unique case (state)
      IDLE: begin
        gnt_n  = '0;
        sel_n  = SEL_IDLE;
        busy_n = 1'b0;
        if (win_valid) begin
          gnt_n   = 6'(6'b1 << win_idx);
          sel_n   = win_idx;
          busy_n  = 1'b1;
          state_n = BUSY;
`ifdef ARB_TIMEOUT_EN
          hold_n = '0;
`endif
        end
      end
      BUSY: begin
        if (!owner_req) begin
          gnt_n   = '0;
          sel_n   = SEL_IDLE;
          busy_n  = 1'b0;
          ptr_n   = (sel == 3'd5) ? 3'd0 : sel + 3'd1;
          state_n = TURN;
        end
`ifdef ARB_TIMEOUT_EN
        // Normal release above wins; forced release only while req[owner] is still high.
        else if (hold == HOLD_LAST) begin
          gnt_n     = '0;
          sel_n     = SEL_IDLE;
          busy_n    = 1'b0;
          ptr_n     = (sel == 3'd5) ? 3'd0 : sel + 3'd1;
          state_n   = TURN;
          timeout_n = 1'b1;
        end else begin
          hold_n = hold + 8'd1;
        end
`endif
      end
      TURN: begin
        gnt_n   = '0;
        sel_n   = SEL_IDLE;
        busy_n  = 1'b0;
        state_n = IDLE;
      end
      default: begin
        gnt_n   = '0;
        sel_n   = SEL_IDLE;
        busy_n  = 1'b0;
        state_n = IDLE;
      end
    endcase
  end

  // State, pointer and registered outputs; reset overrides everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ptr   <= '0;
      gnt   <= '0;
      sel   <= SEL_IDLE;
      busy  <= 1'b0;
    end else begin
      state <= state_n;
      ptr   <= ptr_n;
      gnt   <= gnt_n;
      sel   <= sel_n;
      busy  <= busy_n;
    end
  end

`ifdef ARB_TIMEOUT_EN
  // Hold counter and one-cycle forced-release flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold    <= '0;
      timeout <= 1'b0;
    end else begin
      hold    <= hold_n;
      timeout <= timeout_n;
    end
  end
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_bus_arbiter_6.sv
// Directed self-checking bench for bus_arbiter_6 (hand-computed expectations).
// With ARB_TIMEOUT_EN defined the forced-release sequence is checked,
// otherwise the grant must persist and timeout must stay low.
module tb_bus_arbiter_6;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] req = '0;
  logic [5:0] gnt;
  logic [2:0] sel;
  logic       busy;
  logic       timeout;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  bus_arbiter_6 #(.SEL_IDLE(3'd7), .MAX_HOLD(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .gnt     (gnt),
    .sel     (sel),
    .busy    (busy),
    .timeout (timeout)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_bus(input string tag, input logic [5:0] g, input logic [2:0] s,
                           input logic b);
    check({tag, ".gnt"},  32'(gnt),  32'(g));
    check({tag, ".sel"},  32'(sel),  32'(s));
    check({tag, ".busy"}, 32'(busy), 32'(b));
    check({tag, ".tmo"},  32'(timeout), 32'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] oh;
    // 1: reset with all requests pending
    rst = 1'b1; req = 6'h3F;
    tick(); check_bus("rst_c1", 6'b0, 3'd7, 1'b0);
    tick(); check_bus("rst_c2", 6'b0, 3'd7, 1'b0);
    rst = 1'b0;
    tick(); check_bus("rst_first", 6'b000001, 3'd0, 1'b1);
    req = '0;
    tick(); check_bus("rst_rel", 6'b0, 3'd7, 1'b0);
    tick(); check_bus("rst_turn", 6'b0, 3'd7, 1'b0);

    // 2: single request, other requests ignored while busy, release gap
    req = 6'b000100;
    tick(); check_bus("t2_c1", 6'b000100, 3'd2, 1'b1);
    req = 6'b000101;
    tick(); check_bus("t2_c2", 6'b000100, 3'd2, 1'b1);
    req = 6'b100101;
    tick(); check_bus("t2_c3", 6'b000100, 3'd2, 1'b1);
    req = 6'b000100;
    tick(); check_bus("t2_c4", 6'b000100, 3'd2, 1'b1);
    req = '0;
    tick(); check_bus("t2_c5", 6'b0, 3'd7, 1'b0);
    tick(); check_bus("t2_c6", 6'b0, 3'd7, 1'b0);

    // 3: all requesting, rotation 0..5,0 from a fresh pointer
    rst = 1'b1; tick(); rst = 1'b0;
    req = 6'h3F;
    tick();
    for (int k = 0; k < 7; k++) begin
      int unsigned g;
      g  = k % 6;
      oh = 6'(6'b1 << g);
      for (int c = 0; c < 3; c++) begin
        check_bus($sformatf("t3_g%0d_c%0d", k, c), oh, 3'(g), 1'b1);
        check($sformatf("t3_onehot%0d_%0d", k, c), 32'($countones(gnt) <= 1), 32'd1);
        if (c < 2) tick();
      end
      req = 6'h3F & ~oh;
      tick(); check_bus($sformatf("t3_rel%0d", k), 6'b0, 3'd7, 1'b0);
      req = (k == 6) ? 6'b0 : 6'h3F;
      tick(); check_bus($sformatf("t3_turn%0d", k), 6'b0, 3'd7, 1'b0);
      if (k < 6) tick();
    end
    req = '0; tick();

    // 4: owner 4 releases -> ptr=5, master 5 before master 0
    req = 6'b010000;
    tick(); check_bus("t4_g4", 6'b010000, 3'd4, 1'b1);
    req = 6'b100001;
    tick(); check_bus("t4_rel4", 6'b0, 3'd7, 1'b0);
    tick(); check_bus("t4_turn4", 6'b0, 3'd7, 1'b0);
    tick(); check_bus("t4_g5", 6'b100000, 3'd5, 1'b1);
    req = 6'b000001;
    tick(); check_bus("t4_rel5", 6'b0, 3'd7, 1'b0);
    tick(); check_bus("t4_turn5", 6'b0, 3'd7, 1'b0);
    tick(); check_bus("t4_g0", 6'b000001, 3'd0, 1'b1);
    req = '0;
    tick(); check_bus("t4_rel0", 6'b0, 3'd7, 1'b0);
    tick();

    // 6: reset mid-grant clears the pointer (ptr was 1 before reset)
    req = 6'b000100;
    tick(); check_bus("t6_g2", 6'b000100, 3'd2, 1'b1);
    tick(); check_bus("t6_hold", 6'b000100, 3'd2, 1'b1);
    rst = 1'b1; req = 6'b000101;
    tick(); check_bus("t6_rst", 6'b0, 3'd7, 1'b0);
    rst = 1'b0;
    tick(); check_bus("t6_g0", 6'b000001, 3'd0, 1'b1);
    req = '0;
    tick(); tick();

    // 5: owner 3 never releases while master 1 waits (ptr=1 here)
    req = 6'b001000;
    tick(); check_bus("t5_g3_c1", 6'b001000, 3'd3, 1'b1);
    req = 6'b001010;
`ifdef ARB_TIMEOUT_EN
    for (int c = 2; c <= 4; c++) begin
      tick(); check_bus($sformatf("t5_g3_c%0d", c), 6'b001000, 3'd3, 1'b1);
    end
    tick();
    check("t5_tmo.gnt", 32'(gnt), 32'd0);
    check("t5_tmo.sel", 32'(sel), 32'd7);
    check("t5_tmo.busy", 32'(busy), 32'd0);
    check("t5_tmo.pulse", 32'(timeout), 32'd1);
    tick(); check_bus("t5_turn", 6'b0, 3'd7, 1'b0);
    tick(); check_bus("t5_g1", 6'b000010, 3'd1, 1'b1);
`else
    for (int c = 2; c <= 8; c++) begin
      tick(); check_bus($sformatf("t5_g3_c%0d", c), 6'b001000, 3'd3, 1'b1);
    end
    req = 6'b000010;
    tick(); check_bus("t5_rel3", 6'b0, 3'd7, 1'b0);
    tick(); check_bus("t5_turn", 6'b0, 3'd7, 1'b0);
    tick(); check_bus("t5_g1", 6'b000010, 3'd1, 1'b1);
`endif
    req = '0;
    tick(); check_bus("t5_end", 6'b0, 3'd7, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
